// File: rtl/spi_slave_port.sv
// SPI mode-0 slave port with CPU register map and status/IRQ.
// Optional end-of-packet register enabled by SPI_SLAVE_EOP_EN.
module spi_slave_port #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILL_BYTE   = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [2:0] A_RX = 3'd0;
    localparam logic [2:0] A_TX = 3'd1;
    localparam logic [2:0] A_ST = 3'd2;
    localparam logic [2:0] A_CT = 3'd3;
    localparam logic [2:0] A_EP = 3'd6;

    logic [SYNC_STAGES-1:0] sclk_sync_q, ssn_sync_q, mosi_sync_q;
    logic sclk_dly_q, ssn_dly_q;
    logic sclk_s, ssn_s, mosi_s;
    logic rise, fall, ssn_fall;

    state_t     state_q;
    logic [2:0] bitcnt_q;
    logic [7:0] tx_shift_q, rx_shift_q, rx_hold_q, tx_hold_q;
    logic       primed_q, rrdy_q, roe_q, toe_q, eop_q;
    logic [9:0] ctrl_q;
    logic       rd_strobe_q, wr_strobe_q;
    logic [2:0] rd_addr_q;
    logic       rd_p1, wr_p1, byte_done;
    logic [7:0] rx_byte, tx_next;
    logic [9:0] status_w;
    logic [15:0] rd_mux;
`ifdef SPI_SLAVE_EOP_EN
    logic [15:0] eop_val_q;
`else
    logic unused_wdata;
    assign unused_wdata = ^data_from_cpu[15:10];
`endif

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign ssn_s    = ssn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_dly_q;
    assign fall     = ~sclk_s & sclk_dly_q;
    assign ssn_fall = ~ssn_s & ssn_dly_q;

    assign rd_p1 = ~rd_strobe_q & spi_select & ~read_n;
    assign wr_p1 = ~wr_strobe_q & spi_select & ~write_n;

    assign rx_byte   = {rx_shift_q[6:0], mosi_s};
    assign tx_next   = primed_q ? tx_hold_q : FILL_BYTE;
    assign byte_done = (state_q == ACTIVE) & ~ssn_s & rise
                     & (bitcnt_q == 3'd7);

    assign status_w = {eop_q, roe_q | toe_q, rrdy_q, ~primed_q,
                       ~primed_q & ssn_s, toe_q, roe_q, 3'b000};

    assign MISO    = tx_shift_q[7];
    assign MISO_oe = ~ssn_s;

    always_comb begin
        rd_mux = 16'h0000;
        case (mem_addr)
            A_RX: rd_mux = {8'h00, rx_hold_q};
            A_ST: rd_mux = {6'b0, status_w};
            A_CT: rd_mux = {6'b0, ctrl_q};
`ifdef SPI_SLAVE_EOP_EN
            A_EP: rd_mux = eop_val_q;
`endif
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            ssn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ssn_dly_q   <= 1'b1;
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
            rd_addr_q   <= 3'd0;
            data_to_cpu <= 16'h0000;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-2:0], SS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_dly_q  <= sclk_s;
            ssn_dly_q   <= ssn_s;
            rd_strobe_q <= rd_p1;
            wr_strobe_q <= wr_p1;
            if (rd_p1) begin
                rd_addr_q   <= mem_addr;
                data_to_cpu <= rd_mux;
            end
        end
    end

    // Later assignments win: frame load, then CPU access, then byte completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            bitcnt_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_hold_q  <= 8'h00;
            tx_hold_q  <= 8'h00;
            primed_q   <= 1'b0;
            rrdy_q     <= 1'b0;
            roe_q      <= 1'b0;
            toe_q      <= 1'b0;
            eop_q      <= 1'b0;
            ctrl_q     <= 10'h000;
            irq        <= 1'b0;
`ifdef SPI_SLAVE_EOP_EN
            eop_val_q  <= 16'h0000;
`endif
        end else begin
            irq <= |(status_w & ctrl_q);
            unique case (state_q)
                IDLE: begin
                    if (ssn_fall) begin
                        state_q    <= ACTIVE;
                        tx_shift_q <= tx_next;
                        primed_q   <= 1'b0;
                        bitcnt_q   <= 3'd0;
                    end
                end
                ACTIVE: begin
                    if (ssn_s) begin
                        state_q  <= IDLE;
                        bitcnt_q <= 3'd0;
                    end else if (rise) begin
                        rx_shift_q <= rx_byte;
                        bitcnt_q   <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) rx_hold_q <= rx_byte;
                    end else if (fall) begin
                        if (bitcnt_q == 3'd0) begin
                            tx_shift_q <= tx_next;
                            primed_q   <= 1'b0;
                        end else begin
                            tx_shift_q <= {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            endcase
            if (wr_p1) begin
                case (mem_addr)
                    A_TX: begin
                        if (!primed_q) begin
                            tx_hold_q <= data_from_cpu[7:0];
                            primed_q  <= 1'b1;
                        end else begin
                            toe_q <= 1'b1;
                        end
`ifdef SPI_SLAVE_EOP_EN
                        if (data_from_cpu[7:0] == eop_val_q[7:0])
                            eop_q <= 1'b1;
`endif
                    end
                    A_ST: begin
                        rrdy_q <= 1'b0;
                        roe_q  <= 1'b0;
                        toe_q  <= 1'b0;
                        eop_q  <= 1'b0;
                    end
                    A_CT: ctrl_q <= data_from_cpu[9:0] & 10'h3D8;
`ifdef SPI_SLAVE_EOP_EN
                    A_EP: eop_val_q <= data_from_cpu;
`endif
                    default: ;
                endcase
            end
            if (rd_strobe_q && rd_addr_q == A_RX) rrdy_q <= 1'b0;
            if (byte_done) begin
                rrdy_q <= 1'b1;
                if (rrdy_q) roe_q <= 1'b1;
`ifdef SPI_SLAVE_EOP_EN
                if (rx_byte == eop_val_q[7:0]) eop_q <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench for spi_slave_port: CPU accesses plus a
// behavioural mode-0 SPI master, with queue-based expectations.
module tb_spi_slave_port;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_select = 1'b0;
    logic [2:0]  mem_addr = 3'd0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [15:0] data_from_cpu = 16'h0;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        SCLK = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        MISO_oe;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  miso_q[$];
    logic [7:0]  rx_q[$];
    logic [15:0] rd;
    logic [7:0]  got, exp8;

    spi_slave_port #(.SYNC_STAGES(2), .FILL_BYTE(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .spi_select(spi_select),
        .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
        .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .irq(irq), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe)
    );

    always #10 clk = ~clk;

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        spi_select = 1'b0; write_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
        @(negedge clk);
        d = data_to_cpu;
        @(negedge clk);
        spi_select = 1'b0; read_n = 1'b1;
    endtask

    task automatic ss_begin();
        SS_n = 1'b0; #300;
    endtask

    task automatic ss_end();
        #300; SS_n = 1'b1; #400;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n,
                            output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i >= 8 - n; i--) begin
            MOSI = b[i]; #500;
            SCLK = 1'b1; r[i] = MISO; #500;
            SCLK = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (4) @(posedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (MISO_oe !== 1'b0) begin n_fail++;
            $display("FAIL reset_oe got %b want 0", MISO_oe); end
        n_checks++;
        if (irq !== 1'b0) begin n_fail++;
            $display("FAIL reset_irq got %b want 0", irq); end
        n_checks++;
        if (MISO !== 1'b0) begin n_fail++;
            $display("FAIL reset_miso got %b want 0", MISO); end
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h0060) begin n_fail++;
            $display("FAIL reset_status got %h want 0060", rd); end
        cpu_read(3'd3, rd);
        n_checks++;
        if (rd !== 16'h0000) begin n_fail++;
            $display("FAIL reset_ctrl got %h want 0000", rd); end
    endtask

    task automatic test_basic();
        cpu_write(3'd1, 16'h00A5);
        miso_q.push_back(8'hA5);
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h0000) begin n_fail++;
            $display("FAIL primed_status got %h want 0000", rd); end
        ss_begin();
        n_checks++;
        if (MISO_oe !== 1'b1) begin n_fail++;
            $display("FAIL frame_oe got %b want 1", MISO_oe); end
        rx_q.push_back(8'h3C);
        spi_bits(8'h3C, 8, got);
        ss_end();
        exp8 = miso_q.pop_front();
        n_checks++;
        if (got !== exp8) begin n_fail++;
            $display("FAIL basic_miso got %h want %h", got, exp8); end
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h00E0) begin n_fail++;
            $display("FAIL basic_rrdy got %h want 00E0", rd); end
        cpu_read(3'd0, rd);
        exp8 = rx_q.pop_front();
        n_checks++;
        if (rd !== {8'h00, exp8}) begin n_fail++;
            $display("FAIL basic_rx got %h want %h", rd, exp8); end
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h0060) begin n_fail++;
            $display("FAIL basic_clear got %h want 0060", rd); end
    endtask

    task automatic test_back_to_back();
        cpu_write(3'd1, 16'h005A);
        miso_q.push_back(8'h5A);
        miso_q.push_back(8'h00);
        ss_begin();
        for (int k = 0; k < 2; k++) begin
            exp8 = (k == 0) ? 8'h11 : 8'h22;
            rx_q.push_back(exp8);
            spi_bits(exp8, 8, got);
            exp8 = miso_q.pop_front();
            n_checks++;
            if (got !== exp8) begin n_fail++;
                $display("FAIL b2b_miso%0d got %h want %h", k, got, exp8); end
        end
        ss_end();
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h01E8) begin n_fail++;
            $display("FAIL b2b_roe got %h want 01E8", rd); end
        void'(rx_q.pop_front());
        cpu_read(3'd0, rd);
        exp8 = rx_q.pop_front();
        n_checks++;
        if (rd !== {8'h00, exp8}) begin n_fail++;
            $display("FAIL b2b_rx got %h want %h", rd, exp8); end
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h0060) begin n_fail++;
            $display("FAIL b2b_clear got %h want 0060", rd); end
    endtask

    task automatic test_toe();
        cpu_write(3'd1, 16'h0077);
        miso_q.push_back(8'h77);
        cpu_write(3'd1, 16'h0099);
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h0110) begin n_fail++;
            $display("FAIL toe_set got %h want 0110", rd); end
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h0000) begin n_fail++;
            $display("FAIL toe_clear got %h want 0000", rd); end
        ss_begin();
        spi_bits(8'hC3, 8, got);
        ss_end();
        exp8 = miso_q.pop_front();
        n_checks++;
        if (got !== exp8) begin n_fail++;
            $display("FAIL toe_hold got %h want %h", got, exp8); end
        cpu_read(3'd0, rd);
    endtask

    task automatic test_partial();
        ss_begin();
        spi_bits(8'hFF, 5, got);
        ss_end();
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h0060) begin n_fail++;
            $display("FAIL partial_rrdy got %h want 0060", rd); end
        miso_q.push_back(8'h00);
        rx_q.push_back(8'h81);
        ss_begin();
        spi_bits(8'h81, 8, got);
        ss_end();
        exp8 = miso_q.pop_front();
        n_checks++;
        if (got !== exp8) begin n_fail++;
            $display("FAIL partial_fill got %h want %h", got, exp8); end
        cpu_read(3'd0, rd);
        exp8 = rx_q.pop_front();
        n_checks++;
        if (rd !== {8'h00, exp8}) begin n_fail++;
            $display("FAIL partial_rx got %h want %h", rd, exp8); end
    endtask

    task automatic test_irq();
        int cyc;
        cpu_write(3'd3, 16'hFFFF);
        cpu_read(3'd3, rd);
        n_checks++;
        if (rd !== 16'h03D8) begin n_fail++;
            $display("FAIL ctrl_mask got %h want 03D8", rd); end
        cpu_write(3'd3, 16'h0080);
        repeat (3) @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++;
            $display("FAIL irq_idle got %b want 0", irq); end
        ss_begin();
        spi_bits(8'h42, 8, got);
        ss_end();
        cyc = 0;
        while (irq !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++;
            $display("FAIL irq_rrdy got %b want 1", irq); end
        cpu_read(3'd0, rd);
        repeat (3) @(negedge clk);
        n_checks++;
        if (irq !== 1'b0) begin n_fail++;
            $display("FAIL irq_clear got %b want 0", irq); end
        cpu_write(3'd3, 16'h0000);
    endtask

    task automatic test_eop();
        int cyc;
        cpu_write(3'd6, 16'h000D);
        cpu_read(3'd6, rd);
`ifdef SPI_SLAVE_EOP_EN
        n_checks++;
        if (rd !== 16'h000D) begin n_fail++;
            $display("FAIL eop_reg got %h want 000D", rd); end
        cpu_write(3'd3, 16'h0200);
        ss_begin();
        spi_bits(8'h0D, 8, got);
        ss_end();
        cyc = 0;
        while (irq !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        n_checks++;
        if (irq !== 1'b1) begin n_fail++;
            $display("FAIL eop_irq got %b want 1", irq); end
        cpu_read(3'd2, rd);
        n_checks++;
        if (rd !== 16'h02E0) begin n_fail++;
            $display("FAIL eop_status got %h want 02E0", rd); end
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0000);
`else
        cyc = 0;
        n_checks++;
        if (rd !== 16'h0000) begin n_fail++;
            $display("FAIL eop_absent got %h want 0000 (%0d)", rd, cyc); end
`endif
    endtask

    task automatic test_reset_mid();
        cpu_write(3'd3, 16'h0080);
        ss_begin();
        spi_bits(8'hF0, 3, got);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (MISO_oe !== 1'b0) begin n_fail++;
            $display("FAIL midrst_oe got %b want 0", MISO_oe); end
        n_checks++;
        if (data_to_cpu !== 16'h0000) begin n_fail++;
            $display("FAIL midrst_dout got %h want 0000", data_to_cpu); end
        reset_n = 1'b1;
        ss_end();
        cpu_read(3'd3, rd);
        n_checks++;
        if (rd !== 16'h0000) begin n_fail++;
            $display("FAIL midrst_ctrl got %h want 0000", rd); end
        rx_q.push_back(8'h96);
        ss_begin();
        spi_bits(8'h96, 8, got);
        ss_end();
        cpu_read(3'd0, rd);
        exp8 = rx_q.pop_front();
        n_checks++;
        if (rd !== {8'h00, exp8}) begin n_fail++;
            $display("FAIL midrst_rx got %h want %h", rd, exp8); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_toe();
        test_partial();
        test_irq();
        test_eop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
